md5_iter_core: RTL and testbench

MD5_ITER_CORE -- requirements
Module: md5_iter_core

---
 rtl/md5_pkg.sv | 61 ++++++
 rtl/md5_iter_core_if.sv | 20 ++
 rtl/md5_step.sv | 38 +++
 rtl/md5_iter_core.sv | 125 ++++++++++++
 tb/tb_md5_iter_core.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/md5_pkg.sv
// md5_pkg: shared types and constants for the single-block MD5 iteration core.
//   state_t  - controller states
//   IV_*     - MD5 chaining initial values
//   K_TBL    - 64 additive round constants
//   S_TBL    - 64 left-rotate amounts
//   g_idx    - message word index used by step i
//   bswap32  - byte reversal between MD5 little-endian words and print order
package md5_pkg;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  localparam logic [31:0] IV_A = 32'h67452301;
  localparam logic [31:0] IV_B = 32'hefcdab89;
  localparam logic [31:0] IV_C = 32'h98badcfe;
  localparam logic [31:0] IV_D = 32'h10325476;

  localparam logic [31:0] K_TBL [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  localparam logic [4:0] S_TBL [64] = '{
    5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
    5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
    5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
    5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
    5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
    5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21,
    5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21
  };

  // Only the low nibble of i matters: every formula is taken mod 16.
  function automatic logic [3:0] g_idx(input logic [5:0] i);
    case (i[5:4])
      2'd0:    return i[3:0];
      2'd1:    return 4'd5 * i[3:0] + 4'd1;
      2'd2:    return 4'd3 * i[3:0] + 4'd5;
      default: return 4'd7 * i[3:0];
    endcase
  endfunction

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/md5_iter_core_if.sv
// md5_iter_core_if: message-in / digest-out handshake bundle.
//   in_valid/in_ready/msg/target   - request side (target sampled at accept)
//   out_valid/out_ready            - result handshake
//   digest/msg_out/match           - result payload, stable while out_valid
interface md5_iter_core_if #(parameter int MSG_BYTES = 19);
  logic                   in_valid;
  logic                   in_ready;
  logic [8*MSG_BYTES-1:0] msg;
  logic [127:0]           target;
  logic                   out_valid;
  logic                   out_ready;
  logic [127:0]           digest;
  logic [8*MSG_BYTES-1:0] msg_out;
  logic                   match;

  modport master (output in_valid, msg, target, out_ready,
                  input  in_ready, out_valid, digest, msg_out, match);
  modport slave  (input  in_valid, msg, target, out_ready,
                  output in_ready, out_valid, digest, msg_out, match);
endinterface

// File: rtl/md5_step.sv
// md5_step: one combinational MD5 step.
//   i_a..i_d - current chaining words
//   i_m      - message word M[g(i)]
//   i_k/i_s  - round constant and rotate amount for step i_rnd
//   o_a..o_d - chaining words after the step
module md5_step (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_c,
  input  logic [31:0] i_d,
  input  logic [31:0] i_m,
  input  logic [31:0] i_k,
  input  logic [4:0]  i_s,
  input  logic [5:0]  i_rnd,
  output logic [31:0] o_a,
  output logic [31:0] o_b,
  output logic [31:0] o_c,
  output logic [31:0] o_d
);
  logic [31:0] w_f, w_t, w_rot;

  always_comb begin
    w_f = 32'h0;
    if (i_rnd < 6'd16)      w_f = (i_b & i_c) | (~i_b & i_d);
    else if (i_rnd < 6'd32) w_f = (i_d & i_b) | (~i_d & i_c);
    else if (i_rnd < 6'd48) w_f = i_b ^ i_c ^ i_d;
    else                    w_f = i_c ^ (i_b | ~i_d);
  end

  assign w_t   = i_a + w_f + i_k + i_m;
  // S is never 0, so the right shift amount stays within 1..31.
  assign w_rot = (w_t << i_s) | (w_t >> (6'd32 - {1'b0, i_s}));

  assign o_a = i_d;
  assign o_b = i_b + w_rot;
  assign o_c = i_b;
  assign o_d = i_c;
endmodule

// File: rtl/md5_iter_core.sv
// md5_iter_core: iterative MD5 of a fixed-length (single block) message,
// one step per enabled clock, with optional digest/target comparison.
//   clk, reset_n - clock, async active-low reset
//   en           - global enable; low freezes every register
//   bus          - slave side of md5_iter_core_if
// Accept -> 64 ROUND cycles -> FINAL -> DONE: out_valid 65 clocks after accept.
module md5_iter_core
  import md5_pkg::*;
#(
  parameter int MSG_BYTES = 19,
  parameter bit MATCH_EN  = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            en,
  md5_iter_core_if.slave  bus
);
  localparam int          MW  = 8 * MSG_BYTES;
  localparam logic [15:0] LEN = 16'(8 * MSG_BYTES);

  state_t        r_state, w_state_nxt;
  logic [5:0]    r_cnt;
  logic [31:0]   r_a, r_b, r_c, r_d;
  logic [MW-1:0] r_msg;
  logic [127:0]  r_target, r_digest;
  logic          r_match;

  logic [7:0]    w_blk [64];
  logic [31:0]   w_m   [16];
  logic [31:0]   w_na, w_nb, w_nc, w_nd;
  logic [31:0]   w_fa, w_fb, w_fc, w_fd;
  logic [127:0]  w_dig;

  assign bus.in_ready  = en && (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.digest    = r_digest;
  assign bus.msg_out   = r_msg;
  assign bus.match     = r_match;

  // Padded block: message, 0x80, zeros, 64-bit LE bit length (fits in 2 bytes).
  always_comb begin
    for (int k = 0; k < 64; k++) w_blk[k] = 8'h00;
    for (int k = 0; k < MSG_BYTES; k++) w_blk[k] = r_msg[MW-1-8*k -: 8];
    w_blk[MSG_BYTES] = 8'h80;
    w_blk[56]        = LEN[7:0];
    w_blk[57]        = LEN[15:8];
  end

  always_comb begin
    for (int j = 0; j < 16; j++)
      w_m[j] = {w_blk[4*j+3], w_blk[4*j+2], w_blk[4*j+1], w_blk[4*j]};
  end

  md5_step u_step (
    .i_a(r_a), .i_b(r_b), .i_c(r_c), .i_d(r_d),
    .i_m(w_m[g_idx(r_cnt)]), .i_k(K_TBL[r_cnt]), .i_s(S_TBL[r_cnt]),
    .i_rnd(r_cnt),
    .o_a(w_na), .o_b(w_nb), .o_c(w_nc), .o_d(w_nd)
  );

  assign w_fa  = r_a + IV_A;
  assign w_fb  = r_b + IV_B;
  assign w_fc  = r_c + IV_C;
  assign w_fd  = r_d + IV_D;
  assign w_dig = {bswap32(w_fa), bswap32(w_fb), bswap32(w_fc), bswap32(w_fd)};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else if (en)  r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid)        w_state_nxt = ROUND;
      ROUND:   if (r_cnt == 6'd63)      w_state_nxt = FINAL;
      FINAL:                            w_state_nxt = DONE;
      DONE:    if (bus.out_ready)       w_state_nxt = IDLE;
      default:                          w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_d      <= '0;
      r_msg    <= '0;
      r_target <= '0;
      r_digest <= '0;
      r_match  <= 1'b0;
    end else if (en) begin
      case (r_state)
        IDLE: if (bus.in_valid) begin
          r_msg    <= bus.msg;
          r_target <= bus.target;
          r_a      <= IV_A;
          r_b      <= IV_B;
          r_c      <= IV_C;
          r_d      <= IV_D;
          r_cnt    <= '0;
        end
        ROUND: begin
          r_a <= w_na;
          r_b <= w_nb;
          r_c <= w_nc;
          r_d <= w_nd;
          // Park at 63 so the counter cannot wrap into a second pass.
          if (r_cnt != 6'd63) r_cnt <= r_cnt + 6'd1;
        end
        FINAL: begin
          r_a      <= w_fa;
          r_b      <= w_fb;
          r_c      <= w_fc;
          r_d      <= w_fd;
          r_digest <= w_dig;
          r_match  <= MATCH_EN && (w_dig == r_target);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_md5_iter_core.sv
module tb_md5_iter_core;
  logic clk, reset_n, en;
  int   cyc = 0;
  int   n_tot = 0, n_bad = 0;
  int   acc_q [$];
  logic [127:0] last_dig;

  md5_iter_core_if #(.MSG_BYTES(19)) if19 ();
  md5_iter_core_if #(.MSG_BYTES(1))  if1 ();

  md5_iter_core #(.MSG_BYTES(19), .MATCH_EN(1'b1)) u_dut19 (
    .clk(clk), .reset_n(reset_n), .en(en), .bus(if19));
  md5_iter_core #(.MSG_BYTES(1), .MATCH_EN(1'b1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .en(en), .bus(if1));

  initial begin clk = 1'b0; forever #5 clk = ~clk; end
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // Reference MD5 of one padded block, straight from the algorithm definition;
  // K is derived from the sine formula rather than a table.
  function automatic logic [127:0] md5_ref(input logic [439:0] m, input int nb);
    logic [7:0]  blk [64];
    logic [31:0] w [16];
    logic [31:0] a, b, c, d, f, t, k;
    logic [15:0] len;
    int          sh [16];
    int          g, s;
    real         x;
    sh = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};
    for (int i = 0; i < 64; i++) blk[i] = 8'h00;
    for (int i = 0; i < nb; i++) blk[i] = m[8*(nb-1-i) +: 8];
    blk[nb] = 8'h80;
    len = 16'(8 * nb);
    blk[56] = len[7:0];
    blk[57] = len[15:8];
    for (int j = 0; j < 16; j++)
      w[j] = {blk[4*j+3], blk[4*j+2], blk[4*j+1], blk[4*j]};
    a = 32'h67452301; b = 32'hefcdab89; c = 32'h98badcfe; d = 32'h10325476;
    for (int i = 0; i < 64; i++) begin
      case (i / 16)
        0:       begin f = (b & c) | (~b & d); g = i;              end
        1:       begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
        2:       begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
        default: begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
      endcase
      x = $sin(real'(i + 1));
      if (x < 0.0) x = -x;
      k = 32'(longint'($floor(x * 4294967296.0)));
      s = sh[(i / 16) * 4 + (i % 4)];
      t = a + f + k + w[g];
      t = (t << s) | (t >> (32 - s));
      a = d; d = c; c = b; b = b + t;
    end
    a = a + 32'h67452301; b = b + 32'hefcdab89;
    c = c + 32'h98badcfe; d = d + 32'h10325476;
    return {a[7:0], a[15:8], a[23:16], a[31:24], b[7:0], b[15:8], b[23:16], b[31:24],
            c[7:0], c[15:8], c[23:16], c[31:24], d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  // mode: 0 normal, 1 en dropped 5 clocks mid-round, 2 reset at round 30,
  //       3 in_valid kept high with new msg/target during processing.
  // tmode: 0 random target, 1 target = digest, 2 target one bit off.
  task automatic run19(input logic [151:0] m, input int tmode, input int mode,
                       input int hold, input int exp_lat);
    logic [127:0] e, tgt;
    int n;
    e   = md5_ref({288'b0, m}, 19);
    tgt = (tmode == 1) ? e : (tmode == 2) ? (e ^ 128'h1) :
          {$urandom, $urandom, $urandom, $urandom};
    if19.msg = m; if19.target = tgt; if19.in_valid = 1'b1;
    if19.out_ready = (hold == 0);
    n = 0;
    while (!if19.in_ready && n < 300) begin @(negedge clk); n++; end
    chk("accept19", 128'(n < 300), 128'(1));
    acc_q.push_back(cyc);
    @(negedge clk);
    if (mode == 3) begin if19.msg = ~m; if19.target = ~tgt; end
    else if19.in_valid = 1'b0;
    n = 0;
    while (!if19.out_valid && n < 200) begin
      @(posedge clk); @(negedge clk); n++;
      if (mode == 1 && n == 20) en = 1'b0;
      if (mode == 1 && n == 25) en = 1'b1;
      if (mode == 3 && n == 60) if19.in_valid = 1'b0;
      if (mode == 2 && n == 31) begin
        reset_n = 1'b0;
        #1;
        chk("abort_vld", 128'(if19.out_valid), 128'(0));
        chk("abort_dig", if19.digest, 128'h0);
        chk("abort_msg", 128'(if19.msg_out), 128'h0);
        chk("abort_match", 128'(if19.match), 128'(0));
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        repeat (80) begin @(negedge clk); if (if19.out_valid) n++; end
        chk("abort_noval", 128'(n), 128'(0));
        return;
      end
    end
    last_dig = if19.digest;
    chk("lat19", 128'(n), 128'(exp_lat));
    chk("dig19", if19.digest, e);
    chk("msg19", 128'(if19.msg_out), 128'(m));
    chk("match19", 128'(if19.match), 128'(tmode == 1));
    repeat (hold) begin
      @(negedge clk);
      chk("hold_vld", 128'(if19.out_valid), 128'(1));
      chk("hold_dig", if19.digest, e);
      chk("hold_rdy", 128'(if19.in_ready), 128'(0));
    end
    if19.out_ready = 1'b1;
    @(negedge clk);
    chk("pop19", 128'(if19.out_valid), 128'(0));
  endtask

  task automatic run1(input logic [7:0] m, input int tmode);
    logic [127:0] e, tgt;
    int n;
    e   = md5_ref({432'b0, m}, 1);
    tgt = (tmode == 1) ? e : (tmode == 2) ? (e ^ 128'h1) :
          {$urandom, $urandom, $urandom, $urandom};
    if1.msg = m; if1.target = tgt; if1.in_valid = 1'b1; if1.out_ready = 1'b1;
    n = 0;
    while (!if1.in_ready && n < 300) begin @(negedge clk); n++; end
    chk("accept1", 128'(n < 300), 128'(1));
    @(negedge clk);
    if1.in_valid = 1'b0;
    n = 0;
    while (!if1.out_valid && n < 200) begin @(posedge clk); @(negedge clk); n++; end
    last_dig = if1.digest;
    chk("lat1", 128'(n), 128'(65));
    chk("dig1", if1.digest, e);
    chk("msg1", 128'(if1.msg_out), 128'(m));
    chk("match1", 128'(if1.match), 128'(tmode == 1));
    @(negedge clk);
  endtask

  initial begin
    logic [151:0] rm;
    reset_n = 1'b0; en = 1'b1;
    if19.in_valid = 1'b0; if19.msg = '0; if19.target = '0; if19.out_ready = 1'b1;
    if1.in_valid  = 1'b0; if1.msg  = '0; if1.target  = '0; if1.out_ready  = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_vld", 128'(if19.out_valid), 128'(0));
    chk("rst_dig", if19.digest, 128'h0);
    chk("rst_msg", 128'(if19.msg_out), 128'h0);
    chk("rst_match", 128'(if19.match), 128'(0));
    chk("rst_dig1", if1.digest, 128'h0);
    reset_n = 1'b1;
    en = 1'b0; #1;
    chk("rdy_en0", 128'(if19.in_ready), 128'(0));
    en = 1'b1; #1;
    chk("rdy_en1", 128'(if19.in_ready), 128'(1));
    @(negedge clk);

    run19("The quick brown fox", 1, 0, 0, 65);
    chk("kat_fox", last_dig, 128'ha2004f37730b9445670a738fa0fc9ee5);

    acc_q.delete();
    run19("Hello World 1234567", 0, 0, 0, 65);
    chk("kat_hello", last_dig, 128'hac98cf84ae657376cea165e6729ddb39);
    run19("This is a test. 123", 0, 0, 0, 65);
    chk("kat_test", last_dig, 128'hcaea48685020e1b511a454f660943eaa);
    run19("The quick brown fox", 2, 0, 0, 65);
    chk("gap01", 128'(acc_q[1] - acc_q[0]), 128'(67));
    chk("gap12", 128'(acc_q[2] - acc_q[1]), 128'(67));

    run1("a", 1);
    chk("kat_a", last_dig, 128'h0cc175b9c0f1b6a831c399e269772661);
    run1("a", 2);

    for (int i = 0; i < 19; i++) rm = {rm[143:0], 8'($urandom_range(32, 126))};
    run19(rm, 1, 0, 10, 65);
    for (int i = 0; i < 19; i++) rm = {rm[143:0], 8'($urandom_range(32, 126))};
    run19(rm, 0, 1, 0, 70);
    for (int i = 0; i < 19; i++) rm = {rm[143:0], 8'($urandom_range(32, 126))};
    run19(rm, 1, 3, 0, 65);
    for (int i = 0; i < 19; i++) rm = {rm[143:0], 8'($urandom_range(32, 126))};
    run19(rm, 0, 2, 0, 0);
    run19("The quick brown fox", 1, 0, 0, 65);
    chk("kat_after_abort", last_dig, 128'ha2004f37730b9445670a738fa0fc9ee5);

    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 19; i++) rm = {rm[143:0], 8'($urandom)};
      run19(rm, int'($urandom_range(0, 2)), 0, 0, 65);
    end
    for (int r = 0; r < 3; r++) run1(8'($urandom), int'($urandom_range(0, 2)));

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
